cmd_mode_parser: RTL and testbench
==================================

CMD_MODE_PARSER -- requirements
Module: cmd_mode_parser

Interface
REQ-001 Parameter DW, default 8: width of i_data and o_data; command codes are compared on bits [7:0] with upper bits zero; DW >= 8.
REQ-002 Parameter RATE_W, default 2: width of o_rate; allowed range is 1 to 2.
REQ-003 Parameter TIMEOUT, default 1000: idle cycles allowed in CONTROL before abort; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 i_valid  input  1  i_data holds a byte this cycle.
REQ-007 i_data  input  DW  received byte.
REQ-008 i_wr_ready  input  1  downstream accepts o_data this cycle.
REQ-009 o_data  output  DW  pass-through data byte.
REQ-010 o_wr_en  output  1  o_data valid; held until i_wr_ready.
REQ-011 o_rate  output  RATE_W  committed rate code.
REQ-012 o_rate_state  output  1  parser is in CONTROL.
REQ-013 o_start  output  1  parser is in IDLE and ready for a command.
REQ-014 o_clean  output  1  one-cycle pulse on the clean command.
REQ-015 o_finish  output  1  one-cycle pulse on rate commit.
REQ-016 o_timeout  output  1  one-cycle pulse on CONTROL abort.
REQ-017 o_overrun  output  1  sticky flag: a byte was dropped while in PASS.

Function
REQ-018 States: IDLE, CONTROL, PASS, CLEAN, FINISH; all outputs are registered and update on the same edge as the state.
REQ-019 Only cycles with i_valid=1 are decoded; i_data is ignored when i_valid=0.
REQ-020 IDLE + valid 'M'/'m' (0x4D/0x6D): next state CONTROL; staged rate loaded from o_rate; timeout counter cleared.
REQ-021 IDLE + valid 'C'/'c' (0x43/0x63): next state CLEAN.
REQ-022 IDLE + valid 0x00 or 'F'/'f' (0x46/0x66): stay in IDLE; no output change.
REQ-023 IDLE + any other valid byte: byte captured into o_data; next state PASS with o_wr_en=1 from the next cycle.
REQ-024 PASS: o_data and o_wr_en=1 are held stable until a cycle with i_wr_ready=1; on that edge, next state is IDLE and o_wr_en goes to 0.
REQ-025 PASS + i_valid=1 (any byte, including commands): the byte is dropped and o_overrun is set to 1; the state is unaffected.
REQ-026 CONTROL, valid '1' (0x31): staged rate = 0.
REQ-027 CONTROL, valid '5' (0x35): staged rate = 1.
REQ-028 CONTROL, valid 'A'/'a' (0x41/0x61): staged rate = 2.
REQ-029 CONTROL, valid 'B'/'b' (0x42/0x62): staged rate = 3; when RATE_W=1, values are truncated to the LSB.
REQ-030 CONTROL, any other valid byte: ignored.
REQ-031 In CONTROL, every valid byte clears the timeout counter.
REQ-032 CONTROL + valid 'F'/'f': next state FINISH; o_rate <= staged rate on that edge.
REQ-033 CONTROL + valid 'C'/'c': next state CLEAN; the staged rate is discarded.
REQ-034 CONTROL + valid 'M'/'m': stay in CONTROL; staged rate reloaded from o_rate; counter cleared.
REQ-035 CONTROL timeout (TIMEOUT>0): counter increments each cycle with i_valid=0.
REQ-036 When the counter reaches TIMEOUT-1 with no valid byte: next state IDLE; o_timeout pulses for 1 cycle; staged rate discarded; o_rate unchanged.
REQ-037 Timeout counter width is $clog2(TIMEOUT+1); it saturates and never wraps.
REQ-038 FINISH: lasts 1 cycle; o_finish=1; next state IDLE; a byte arriving in this cycle is ignored.
REQ-039 CLEAN: lasts 1 cycle; o_clean=1; o_rate <= 0; o_overrun <= 0; next state IDLE; a byte arriving in this cycle is ignored.
REQ-040 o_rate_state=1 exactly while in CONTROL.
REQ-041 o_start=1 exactly while in IDLE.
REQ-042 Latency: a valid byte at edge n is reflected in the state and outputs at edge n+1.

Reset
REQ-043 reset=0 sampled at posedge clk forces state=IDLE, o_data=0, o_wr_en=0, o_rate=0, staged rate=0, counter=0, and o_rate_state, o_start, o_clean, o_finish, o_timeout, o_overrun all 0.
REQ-044 o_start=1 from the first edge after reset returns to 1.
REQ-045 Reset asserted mid-PASS or mid-CONTROL aborts the operation with no write, no commit and no pulse.

Verification
REQ-046 Bytes 'M','5','F', each with i_valid=1 on consecutive cycles -> o_rate_state=1 for 2 cycles, o_finish pulses once, then o_rate=1 and o_start=1.
REQ-047 Byte 0x30 with i_wr_ready=0 for 3 cycles, then 1 -> o_wr_en=1 and o_data=0x30 for 4 cycles, then o_wr_en=0 and state IDLE.
REQ-048 TIMEOUT=4, bytes 'M','A', then idle -> o_timeout pulses 4 cycles after 'A'; o_rate keeps its prior value of 0.
REQ-049 Byte 0x41 in PASS with i_wr_ready=0 -> o_overrun=1; a later 'C' -> o_clean pulse, o_overrun=0, o_rate=0.
REQ-050 Bytes 'M','B', then reset=0 for 1 cycle, then 'F' -> all outputs at reset values, o_rate=0, no o_finish pulse.

Source files
------------

// File: rtl/cmd_mode_parser.sv
// Byte-stream command parser. It recognises mode/clean/finish commands, stages and commits
// a rate code, and forwards all other bytes through a held write handshake.
module cmd_mode_parser #(
    parameter int DW      = 8,
    parameter int RATE_W  = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DW-1:0]     i_data,
    input  logic              i_wr_ready,
    output logic [DW-1:0]     o_data,
    output logic              o_wr_en,
    output logic [RATE_W-1:0] o_rate,
    output logic              o_rate_state,
    output logic              o_start,
    output logic              o_clean,
    output logic              o_finish,
    output logic              o_timeout,
    output logic              o_overrun
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {IDLE, CONTROL, PASS, CLEAN, FINISH} state_t;

    state_t              state, state_n;
    logic [RATE_W-1:0]   staged, staged_n, rate_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [DW-1:0]       data_n;
    logic                wr_en_n, overrun_n, timeout_n;

    function automatic logic [RATE_W-1:0] rate_code(input logic [1:0] v);
        return v[RATE_W-1:0];
    endfunction

    // A command matches only when the bits above the low byte are zero.
    function automatic logic is_cmd(input logic [DW-1:0] d, input logic [7:0] code);
        return ((d >> 8) == '0) && (d[7:0] == code);
    endfunction

    always_comb begin
        state_n   = state;
        staged_n  = staged;
        cnt_n     = cnt;
        data_n    = o_data;
        wr_en_n   = o_wr_en;
        rate_n    = o_rate;
        overrun_n = o_overrun;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (is_cmd(i_data, 8'h4D) || is_cmd(i_data, 8'h6D)) begin
                        state_n  = CONTROL;
                        staged_n = o_rate;
                        cnt_n    = '0;
                    end else if (is_cmd(i_data, 8'h43) || is_cmd(i_data, 8'h63)) begin
                        state_n   = CLEAN;
                        rate_n    = '0;
                        overrun_n = 1'b0;
                    end else if (!(is_cmd(i_data, 8'h00) || is_cmd(i_data, 8'h46)
                                   || is_cmd(i_data, 8'h66))) begin
                        state_n = PASS;
                        data_n  = i_data;
                        wr_en_n = 1'b1;
                    end
                end
            end
            CONTROL: begin
                if (i_valid) begin
                    cnt_n = '0;
                    if (is_cmd(i_data, 8'h46) || is_cmd(i_data, 8'h66)) begin
                        state_n = FINISH;
                        rate_n  = staged;
                    end else if (is_cmd(i_data, 8'h43) || is_cmd(i_data, 8'h63)) begin
                        state_n   = CLEAN;
                        rate_n    = '0;
                        overrun_n = 1'b0;
                    end else if (is_cmd(i_data, 8'h4D) || is_cmd(i_data, 8'h6D)) begin
                        staged_n = o_rate;
                    end else if (is_cmd(i_data, 8'h31)) begin
                        staged_n = rate_code(2'd0);
                    end else if (is_cmd(i_data, 8'h35)) begin
                        staged_n = rate_code(2'd1);
                    end else if (is_cmd(i_data, 8'h41) || is_cmd(i_data, 8'h61)) begin
                        staged_n = rate_code(2'd2);
                    end else if (is_cmd(i_data, 8'h42) || is_cmd(i_data, 8'h62)) begin
                        staged_n = rate_code(2'd3);
                    end
                end else if (TIMEOUT > 0) begin
                    if (cnt == CNT_LAST) begin
                        state_n   = IDLE;
                        timeout_n = 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            PASS: begin
                if (i_valid) overrun_n = 1'b1;
                if (i_wr_ready) begin
                    state_n = IDLE;
                    wr_en_n = 1'b0;
                end
            end
            CLEAN:   state_n = IDLE;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            staged       <= '0;
            cnt          <= '0;
            o_data       <= '0;
            o_wr_en      <= 1'b0;
            o_rate       <= '0;
            o_overrun    <= 1'b0;
            o_timeout    <= 1'b0;
            o_start      <= 1'b0;
            o_rate_state <= 1'b0;
            o_clean      <= 1'b0;
            o_finish     <= 1'b0;
        end else begin
            state        <= state_n;
            staged       <= staged_n;
            cnt          <= cnt_n;
            o_data       <= data_n;
            o_wr_en      <= wr_en_n;
            o_rate       <= rate_n;
            o_overrun    <= overrun_n;
            o_timeout    <= timeout_n;
            o_start      <= (state_n == IDLE);
            o_rate_state <= (state_n == CONTROL);
            o_clean      <= (state_n == CLEAN);
            o_finish     <= (state_n == FINISH);
        end
    end

endmodule

// File: tb/tb_cmd_mode_parser.sv
// Bench for cmd_mode_parser: directed vector table, hand-written corner sequences, and
// randomized traffic against a behavioural model that counts idle cycles in CONTROL.
module tb_cmd_mode_parser;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_wr_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_wr_en;
    logic [1:0] o_rate;
    logic       o_rate_state, o_start, o_clean, o_finish, o_timeout, o_overrun;

    int total = 0;
    int bad   = 0;

    cmd_mode_parser #(.DW(8), .RATE_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_data(i_data),
        .i_wr_ready(i_wr_ready), .o_data(o_data), .o_wr_en(o_wr_en), .o_rate(o_rate),
        .o_rate_state(o_rate_state), .o_start(o_start), .o_clean(o_clean),
        .o_finish(o_finish), .o_timeout(o_timeout), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    // Behavioural reference: mode names, idle-cycle count in CONTROL.
    typedef enum int {M_IDLE, M_CTRL, M_PASS, M_CLEAN, M_FIN} mode_t;
    mode_t      m_mode = M_IDLE;
    logic [1:0] m_rate = 0, m_stage = 0;
    logic [7:0] m_data = 0;
    logic       m_wr = 0, m_ovr = 0, m_to = 0, m_up = 0;
    int         m_idle = 0;

    task automatic model_step(input logic rst_n, input logic v, input logic [7:0] d,
                              input logic r);
        m_to = 0;
        if (!rst_n) begin
            m_mode = M_IDLE; m_rate = 0; m_stage = 0; m_data = 0; m_wr = 0; m_ovr = 0;
            m_idle = 0; m_up = 0;
            return;
        end
        m_up = 1;
        case (m_mode)
            M_IDLE: if (v) begin
                if (d == "M" || d == "m") begin
                    m_mode = M_CTRL; m_stage = m_rate; m_idle = 0;
                end else if (d == "C" || d == "c") begin
                    m_mode = M_CLEAN; m_rate = 0; m_ovr = 0;
                end else if (d != 8'h00 && d != "F" && d != "f") begin
                    m_mode = M_PASS; m_data = d; m_wr = 1;
                end
            end
            M_CTRL: if (v) begin
                m_idle = 0;
                case (d)
                    "F", "f": begin m_mode = M_FIN; m_rate = m_stage; end
                    "C", "c": begin m_mode = M_CLEAN; m_rate = 0; m_ovr = 0; end
                    "M", "m": m_stage = m_rate;
                    "1":      m_stage = 0;
                    "5":      m_stage = 1;
                    "A", "a": m_stage = 2;
                    "B", "b": m_stage = 3;
                    default:  ;
                endcase
            end else begin
                m_idle++;
                if (m_idle == TO) begin m_mode = M_IDLE; m_to = 1; end
            end
            M_PASS: begin
                if (v) m_ovr = 1;
                if (r) begin m_mode = M_IDLE; m_wr = 0; end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [16:0] model_vec();
        return {m_data, m_wr, m_up && m_mode == M_IDLE, m_up && m_mode == M_CTRL,
                m_up && m_mode == M_CLEAN, m_up && m_mode == M_FIN, m_to, m_ovr, m_rate};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {o_data, o_wr_en, o_start, o_rate_state, o_clean, o_finish, o_timeout,
                o_overrun, o_rate};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        reset = rst_n; i_valid = v; i_data = d; i_wr_ready = r;
        @(posedge clk);
        model_step(rst_n, v, d, r);
        #1;
    endtask

    typedef struct {
        logic       rst_n, v;
        logic [7:0] d;
        logic       r;
        logic [7:0] e_data;
        logic       e_wr, e_start, e_ctrl, e_clean, e_fin, e_to, e_ovr;
        logic [1:0] e_rate;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_n, input logic v, input logic [7:0] d, input logic r,
                       input logic [7:0] ed, input logic [7:0] flags, input logic [1:0] er);
        vec_t t;
        t.rst_n = rst_n; t.v = v; t.d = d; t.r = r; t.e_data = ed;
        {t.e_wr, t.e_start, t.e_ctrl, t.e_clean, t.e_fin, t.e_to, t.e_ovr} = flags[6:0];
        t.e_rate = er;
        tbl.push_back(t);
    endtask

    logic [7:0] picks [14] = '{8'h4D, 8'h6D, 8'h43, 8'h63, 8'h46, 8'h66, 8'h00,
                               8'h31, 8'h35, 8'h41, 8'h61, 8'h42, 8'h62, 8'h30};

    initial begin
        // flags: wr start ctrl clean fin to ovr
        add(0, 0, 8'h00, 0, 8'h00, 7'b0000000, 0);  // reset
        add(1, 0, 8'h00, 0, 8'h00, 7'b0100000, 0);
        add(1, 1, 8'h4D, 0, 8'h00, 7'b0010000, 0);  // M 5 F
        add(1, 1, 8'h35, 0, 8'h00, 7'b0010000, 0);
        add(1, 1, 8'h46, 0, 8'h00, 7'b0000100, 1);
        add(1, 0, 8'h00, 0, 8'h00, 7'b0100000, 1);
        add(1, 1, 8'h30, 0, 8'h30, 7'b1000000, 1);  // pass, held 4 cycles
        add(1, 0, 8'h00, 0, 8'h30, 7'b1000000, 1);
        add(1, 0, 8'h00, 0, 8'h30, 7'b1000000, 1);
        add(1, 0, 8'h00, 0, 8'h30, 7'b1000000, 1);
        add(1, 0, 8'h00, 1, 8'h30, 7'b0100000, 1);
        add(1, 1, 8'h30, 0, 8'h30, 7'b1000000, 1);  // overrun then clean
        add(1, 1, 8'h41, 0, 8'h30, 7'b1000001, 1);
        add(1, 0, 8'h00, 1, 8'h30, 7'b0100001, 1);
        add(1, 1, 8'h43, 0, 8'h30, 7'b0001000, 0);
        add(1, 0, 8'h00, 0, 8'h30, 7'b0100000, 0);
        add(1, 1, 8'h4D, 0, 8'h30, 7'b0010000, 0);  // M B reset F
        add(1, 1, 8'h42, 0, 8'h30, 7'b0010000, 0);
        add(0, 0, 8'h00, 0, 8'h00, 7'b0000000, 0);
        add(1, 1, 8'h46, 0, 8'h00, 7'b0100000, 0);
        add(1, 0, 8'h00, 0, 8'h00, 7'b0100000, 0);
        add(1, 1, 8'h4D, 0, 8'h00, 7'b0010000, 0);  // M A then timeout
        add(1, 1, 8'h41, 0, 8'h00, 7'b0010000, 0);
        add(1, 0, 8'h00, 0, 8'h00, 7'b0010000, 0);
        add(1, 0, 8'h00, 0, 8'h00, 7'b0010000, 0);
        add(1, 0, 8'h00, 0, 8'h00, 7'b0010000, 0);
        add(1, 0, 8'h00, 0, 8'h00, 7'b0100010, 0);
        add(1, 0, 8'h00, 0, 8'h00, 7'b0100000, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].v, tbl[i].d, tbl[i].r);
            check($sformatf("vec%0d", i), {15'd0, dut_vec()},
                  {15'd0, tbl[i].e_data, tbl[i].e_wr, tbl[i].e_start, tbl[i].e_ctrl,
                   tbl[i].e_clean, tbl[i].e_fin, tbl[i].e_to, tbl[i].e_ovr, tbl[i].e_rate});
        end

        // Byte during FINISH is ignored.
        drive(1, 1, "M", 0); drive(1, 1, "B", 0); drive(1, 1, "F", 0);
        check("fin_rate", {30'd0, o_rate}, 32'd3);
        drive(1, 1, "M", 0);
        check("fin_ignore", {30'd0, o_start, o_rate_state}, 32'b10);
        // Clean from CONTROL clears the committed rate.
        drive(1, 1, "m", 0); drive(1, 1, "a", 0); drive(1, 1, "c", 0);
        check("ctrl_clean", {29'd0, o_clean, o_rate}, 32'b100);
        // Reset mid-PASS drops the write.
        drive(1, 0, 8'h00, 0); drive(1, 1, 8'h55, 0);
        check("pass_wr", {23'd0, o_wr_en, o_data}, {23'd0, 1'b1, 8'h55});
        drive(0, 0, 8'h00, 1);
        check("pass_rst", {23'd0, o_wr_en, o_data}, 32'd0);

        // Randomized traffic against the model.
        drive(0, 0, 8'h00, 0);
        check("rand_rst", {15'd0, dut_vec()}, {15'd0, model_vec()});
        for (int n = 0; n < 3000; n++) begin
            logic       rv, rr, rst_n;
            logic [7:0] rd;
            rv    = ($urandom_range(0, 99) < 45);
            rr    = ($urandom_range(0, 99) < 35);
            rst_n = ($urandom_range(0, 99) >= 2);
            rd    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : picks[$urandom_range(0, 13)];
            drive(rst_n, rv, rd, rr);
            check($sformatf("rand%0d", n), {15'd0, dut_vec()}, {15'd0, model_vec()});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
